// File: rtl/fetch_queue.sv
// Instruction fetch front-end: issues sequential PCs to a 1-cycle-latency
// instruction memory and buffers the returned {pc, instr} pairs for decode.
module fetch_queue #(
   parameter int PC_W  = 9,
   parameter int INS_W = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       imem_req,
   output logic [PC_W-1:0]            imem_addr,
   input  logic [INS_W-1:0]           imem_rdata,
   input  logic                       redirect,
   input  logic [PC_W-1:0]            redirect_pc,
   input  logic                       id_stall,
   output logic                       out_valid,
   output logic [PC_W-1:0]            out_pc,
   output logic [INS_W-1:0]           out_instr,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [PC_W-1:0]  fetch_pc;
   logic             vld_p1;
   logic [PC_W-1:0]  pc_p1;

   logic [PC_W-1:0]  fifo_pc  [DEPTH];
   logic [INS_W-1:0] fifo_ins [DEPTH];
   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;
   logic [CW-1:0]    count;

   logic [CW:0]      credit;
   logic             issue;
   logic             push;
   logic             pop;

   // Stage p0: credit check counts the outstanding request so the FIFO never overflows
   assign credit    = {1'b0, count} + (CW+1)'(vld_p1);
   assign issue     = !reset && !redirect && (credit < (CW+1)'(DEPTH));
   assign imem_req  = issue;
   assign imem_addr = fetch_pc;

   assign push      = vld_p1 && !redirect && !reset;
   assign out_valid = (count != '0);
   assign pop       = out_valid && !id_stall && !redirect && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= '0;
         vld_p1   <= 1'b0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc & ~PC_W'(3);
         vld_p1   <= 1'b0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         if (issue)
            fetch_pc <= fetch_pc + PC_W'(4);
         vld_p1 <= issue;
         if (push)
            tail <= tail + AW'(1);
         if (pop)
            head <= head + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Stage p1: memory response returns, tagged with the PC captured at issue
   always_ff @(posedge clk) begin
      if (issue)
         pc_p1 <= fetch_pc;
      if (push) begin
         fifo_pc[tail]  <= pc_p1;
         fifo_ins[tail] <= imem_rdata;
      end
   end

   // Stage p2: FIFO head to decode; an empty queue presents a NOP bubble
   assign out_pc    = out_valid ? fifo_pc[head]  : '0;
   assign out_instr = out_valid ? fifo_ins[head] : '0;
   assign occupancy = count;

endmodule
